// File: rtl/regfile_sb_if.sv
// Register-file bus: write port, two read ports, scoreboard issue/status and
// clear-sweep control. The driver side is the master, the file is the slave.
interface regfile_sb_if #(
  parameter int DW = 16,
  parameter int AW = 3
);
  logic          we;
  logic [AW-1:0] W_Adr;
  logic [DW-1:0] W;
  logic [AW-1:0] R_Adr;
  logic [AW-1:0] S_Adr;
  logic [DW-1:0] R;
  logic [DW-1:0] S;
  logic          iss_valid;
  logic [AW-1:0] iss_Adr;
  logic          R_busy;
  logic          S_busy;
  logic          clr_req;
  logic          clr_busy;
  logic          clr_done;

  modport master (
    output we, W_Adr, W, R_Adr, S_Adr, iss_valid, iss_Adr, clr_req,
    input  R, S, R_busy, S_busy, clr_busy, clr_done
  );

  modport slave (
    input  we, W_Adr, W, R_Adr, S_Adr, iss_valid, iss_Adr, clr_req,
    output R, S, R_busy, S_busy, clr_busy, clr_done
  );
endinterface

// File: rtl/regfile_sb.sv
// 2**AW x DW register file with two combinational read ports, a per-register
// busy scoreboard and a one-register-per-cycle clear sweep.
// Optional: define REGFILE_SB_BYPASS_EN to forward write data to the read
// ports in the same cycle.
module regfile_sb #(
  parameter int DW = 16,
  parameter int AW = 3
) (
  input  logic         clk,
  input  logic         reset,
  regfile_sb_if.slave  bus
);
  localparam int DEPTH = 1 << AW;

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t                     state_q;
  logic [AW-1:0]              ptr_q;
  logic                       clr_done_q;
  logic [DEPTH-1:0][DW-1:0]   mem_q;
  logic [DEPTH-1:0]           busy_q;
  logic                       idle;

  assign idle = (state_q == IDLE);

  // Sweep control: enter CLEAR on request, walk ptr, pulse done on the way out
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      clr_done_q <= 1'b0;
    end else begin
      clr_done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.clr_req) begin
            state_q <= CLEAR;
            ptr_q   <= '0;
          end
        end
        CLEAR: begin
          // ptr wraps back to 0 on the last register, ready for the next sweep
          ptr_q <= ptr_q + 1'b1;
          if (ptr_q == '1) begin
            state_q    <= IDLE;
            clr_done_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Array and scoreboard; the issue set is ordered last so it beats a write clear
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_q  <= '0;
      busy_q <= '0;
    end else if (!idle) begin
      mem_q[ptr_q] <= '0;
    end else if (bus.clr_req) begin
      busy_q <= '0;
    end else begin
      if (bus.we) begin
        mem_q[bus.W_Adr]  <= bus.W;
        busy_q[bus.W_Adr] <= 1'b0;
      end
      if (bus.iss_valid) busy_q[bus.iss_Adr] <= 1'b1;
    end
  end

`ifdef REGFILE_SB_BYPASS_EN
  logic byp;
  // Forward only when the write will actually land; reset keeps reads at 0
  assign byp = reset && idle && bus.we && !bus.clr_req;

  // Read ports with write-through forwarding
  always_comb begin
    bus.R = mem_q[bus.R_Adr];
    bus.S = mem_q[bus.S_Adr];
    if (byp && (bus.R_Adr == bus.W_Adr)) bus.R = bus.W;
    if (byp && (bus.S_Adr == bus.W_Adr)) bus.S = bus.W;
  end
`else
  assign bus.R = mem_q[bus.R_Adr];
  assign bus.S = mem_q[bus.S_Adr];
`endif

  assign bus.R_busy   = busy_q[bus.R_Adr];
  assign bus.S_busy   = busy_q[bus.S_Adr];
  assign bus.clr_busy = !idle;
  assign bus.clr_done = clr_done_q;
endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: directed scenarios plus random traffic, checked
// against an array-based reference model of the register file.
module tb_regfile_sb;
  localparam int DW = 16;
  localparam int AW = 3;
  localparam int N  = 1 << AW;
`ifdef REGFILE_SB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  regfile_sb_if #(.DW(DW), .AW(AW)) bus();
  regfile_sb #(.DW(DW), .AW(AW)) dut (.clk(clk), .reset(reset), .bus(bus.slave));

  int total = 0;
  int bad   = 0;

  // Reference model: contents, busy flags, sweep cycles remaining, done flag
  logic [DW-1:0] m_mem [N];
  bit            m_busy [N];
  int            m_left;
  bit            m_done;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < N; i++) begin
      m_mem[i]  = '0;
      m_busy[i] = 1'b0;
    end
    m_left = 0;
    m_done = 1'b0;
  endfunction

  // One clock edge of the model, using inputs as they stand at the edge
  function automatic void model_edge();
    if (m_left > 0) begin
      m_mem[N - m_left] = '0;
      m_left--;
      m_done = (m_left == 0);
    end else begin
      m_done = 1'b0;
      if (bus.clr_req) begin
        for (int i = 0; i < N; i++) m_busy[i] = 1'b0;
        m_left = N;
      end else begin
        if (bus.we) begin
          m_mem[bus.W_Adr]  = bus.W;
          m_busy[bus.W_Adr] = 1'b0;
        end
        if (bus.iss_valid) m_busy[bus.iss_Adr] = 1'b1;
      end
    end
  endfunction

  function automatic logic [DW-1:0] exp_rd(input logic [AW-1:0] a);
    if (!reset) return '0;
    if (BYP && m_left == 0 && bus.we && !bus.clr_req && bus.W_Adr == a) return bus.W;
    return m_mem[a];
  endfunction

  task automatic check_all();
    chk("R",        bus.R,        exp_rd(bus.R_Adr));
    chk("S",        bus.S,        exp_rd(bus.S_Adr));
    chk("R_busy",   bus.R_busy,   reset ? m_busy[bus.R_Adr] : 1'b0);
    chk("S_busy",   bus.S_busy,   reset ? m_busy[bus.S_Adr] : 1'b0);
    chk("clr_busy", bus.clr_busy, (reset && m_left > 0));
    chk("clr_done", bus.clr_done, m_done);
  endtask

  task automatic tick();
    @(posedge clk);
    if (reset) model_edge();
    #1;
  endtask

  task automatic drive(input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] w,
                       input logic [AW-1:0] ra, input logic [AW-1:0] sa,
                       input logic iv, input logic [AW-1:0] ia, input logic clr);
    bus.we = we; bus.W_Adr = wa; bus.W = w;
    bus.R_Adr = ra; bus.S_Adr = sa;
    bus.iss_valid = iv; bus.iss_Adr = ia; bus.clr_req = clr;
  endtask

  task automatic drive_rand(input bit allow_clr);
    drive(1'($urandom), 3'($urandom), 16'($urandom), 3'($urandom), 3'($urandom),
          1'($urandom), 3'($urandom), allow_clr && ($urandom_range(0, 39) == 0));
  endtask

  task automatic cyc();
    @(negedge clk);
    check_all();
    tick();
  endtask

  task automatic load_all();
    for (int i = 0; i < N; i++) begin
      drive(1'b1, 3'(i), 16'($urandom) | 16'h0001, 3'(i), 3'(N - 1 - i), 1'b0, '0, 1'b0);
      cyc();
    end
  endtask

  int nb, np;

  initial begin
    model_reset();
    // Reset: outputs held at 0 even with a colliding write presented
    reset = 1'b0;
    drive(1'b1, 3'd3, 16'hFFFF, 3'd3, 3'd3, 1'b1, 3'd3, 1'b0);
    #3;
    chk("rst_R", bus.R, 16'h0);
    chk("rst_S", bus.S, 16'h0);
    chk("rst_clr_busy", bus.clr_busy, 1'b0);
    chk("rst_clr_done", bus.clr_done, 1'b0);
    @(negedge clk); check_all();
    @(posedge clk); #1;
    reset = 1'b1;

    // Write 0x1234 to reg 5, read back on both ports
    drive(1'b1, 3'd5, 16'h1234, 3'd0, 3'd0, 1'b0, '0, 1'b0); cyc();
    drive(1'b0, 3'd0, 16'h0, 3'd5, 3'd5, 1'b0, '0, 1'b0);
    @(negedge clk); check_all();
    chk("w5_R", bus.R, 16'h1234);
    chk("w5_S", bus.S, 16'h1234);
    tick();

    // Issue to reg 2, then retire it with a write of 0xBEEF
    drive(1'b0, 3'd0, 16'h0, 3'd2, 3'd0, 1'b1, 3'd2, 1'b0);
    @(negedge clk); check_all();
    chk("iss2_nofwd", bus.R_busy, 1'b0);
    tick();
    drive(1'b1, 3'd2, 16'hBEEF, 3'd2, 3'd0, 1'b0, '0, 1'b0);
    @(negedge clk); check_all();
    chk("iss2_busy", bus.R_busy, 1'b1);
    tick();
    drive(1'b0, 3'd0, 16'h0, 3'd2, 3'd0, 1'b0, '0, 1'b0);
    @(negedge clk); check_all();
    chk("ret2_busy", bus.R_busy, 1'b0);
    chk("ret2_R", bus.R, 16'hBEEF);
    tick();

    // Issue and write to reg 4 together: data lands, busy stays set
    drive(1'b1, 3'd4, 16'h4444, 3'd0, 3'd0, 1'b1, 3'd4, 1'b0); cyc();
    drive(1'b0, 3'd0, 16'h0, 3'd4, 3'd4, 1'b0, '0, 1'b0);
    @(negedge clk); check_all();
    chk("both4_S", bus.S, 16'h4444);
    chk("both4_Sbusy", bus.S_busy, 1'b1);
    tick();

    // Write-to-read forwarding on reg 1
    drive(1'b1, 3'd1, 16'h5555, 3'd0, 3'd0, 1'b0, '0, 1'b0); cyc();
    drive(1'b1, 3'd1, 16'h00AA, 3'd1, 3'd1, 1'b0, '0, 1'b0);
    @(negedge clk); check_all();
    chk("byp_R", bus.R, BYP ? 16'h00AA : 16'h5555);
    tick();
    drive(1'b0, 3'd0, 16'h0, 3'd1, 3'd1, 1'b0, '0, 1'b0);
    @(negedge clk); check_all();
    chk("after_byp_R", bus.R, 16'h00AA);
    tick();

    // Random traffic with occasional sweeps
    for (int k = 0; k < 300; k++) begin
      drive_rand(1'b1);
      cyc();
    end

    // Drain any sweep in flight (bounded)
    for (int k = 0; k < 2 * N + 2 && (m_left > 0 || m_done); k++) begin
      drive(1'b0, '0, '0, '0, '0, 1'b0, '0, 1'b0);
      cyc();
    end
    chk("drain_idle", (m_left == 0), 1'b1);

    // Full sweep with traffic during CLEAR that must be ignored
    load_all();
    drive(1'b0, '0, '0, 3'd0, 3'd7, 1'b0, '0, 1'b1); cyc();
    nb = 0; np = 0;
    for (int k = 0; k < 3 * N && np == 0; k++) begin
      if (m_left > 0) drive_rand(1'b0);
      else drive(1'b0, '0, '0, 3'($urandom), 3'($urandom), 1'b0, '0, 1'b0);
      if (m_left > 0) bus.clr_req = 1'($urandom);
      @(negedge clk); check_all();
      if (bus.clr_busy === 1'b1) nb++;
      if (bus.clr_done === 1'b1) np++;
      tick();
    end
    chk("sweep_cycles", nb, N);
    chk("sweep_done_pulses", np, 1);
    for (int i = 0; i < N; i++) begin
      drive(1'b0, '0, '0, 3'(i), 3'(N - 1 - i), 1'b0, '0, 1'b0);
      @(negedge clk); check_all();
      chk("swept_R", bus.R, 16'h0);
      chk("swept_done_low", bus.clr_done, 1'b0);
      tick();
    end

    // Reset dropped mid-sweep aborts it
    load_all();
    drive(1'b0, '0, '0, 3'd7, 3'd6, 1'b0, '0, 1'b1); cyc();
    drive(1'b0, '0, '0, 3'd7, 3'd6, 1'b0, '0, 1'b0);
    for (int k = 0; k < 3; k++) cyc();
    #1;
    reset = 1'b0;
    model_reset();
    #1;
    chk("abort_R", bus.R, 16'h0);
    chk("abort_S", bus.S, 16'h0);
    chk("abort_clr_busy", bus.clr_busy, 1'b0);
    @(posedge clk); #1;
    reset = 1'b1;
    for (int k = 0; k < 2 * N; k++) begin
      drive(1'b0, '0, '0, 3'(k), 3'(k + 3), 1'b0, '0, 1'b0);
      @(negedge clk); check_all();
      chk("post_abort_R", bus.R, 16'h0);
      chk("post_abort_done", bus.clr_done, 1'b0);
      chk("post_abort_busy", bus.clr_busy, 1'b0);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
